// File: rtl/text_line_server_if.sv
// rtl/text_line_server_if.sv - read port, character-write and number-write handshakes of text_line_server
interface text_line_server_if;
   logic [7:0] char_xy;
   logic [6:0] char_code;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_xy;
   logic [6:0] wr_code;
   logic       num_valid;
   logic       num_ready;
   logic [7:0] num_xy;
   logic [9:0] num_value;
   logic       busy;

   // Game logic / drawer side
   modport master (
      output char_xy, wr_valid, wr_xy, wr_code, num_valid, num_xy, num_value,
      input  char_code, wr_ready, num_ready, busy
   );

   // Character buffer side
   modport slave (
      input  char_xy, wr_valid, wr_xy, wr_code, num_valid, num_xy, num_value,
      output char_code, wr_ready, num_ready, busy
   );
endinterface

// File: rtl/text_line_server.sv
// rtl/text_line_server.sv - 256-cell character buffer with char writes and 3-digit number writes
module text_line_server #(
   parameter logic [6:0] SPACE_CODE = 7'h20,
   parameter logic [6:0] DIGIT_BASE = 7'h30
) (
   input  logic               clk,
   input  logic               rst,
   text_line_server_if.slave  bus
);

   typedef enum logic [2:0] {CLEAR, IDLE, CONV, WR0, WR1, WR2} state_t;

   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d;      // clear sweep address
   logic [7:0]  pos_q, pos_d;        // captured hundreds-digit position
   logic [21:0] shift_q, shift_d;    // {bcd[11:0], binary[9:0]} double-dabble register
   logic [3:0]  cnt_q, cnt_d;        // conversion iteration
   logic [6:0]  char_code_q, char_code_d;

   logic [6:0]  mem [256];
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [6:0]  mem_data;

   logic [9:0]  num_sat;
   logic [3:0]  hund, tens, units;

   // One shift-and-add-3 step: correct each BCD nibble >= 5, then shift left
   function automatic logic [21:0] bcd_step(input logic [21:0] s);
      logic [21:0] t;
      t = s;
      for (int i = 0; i < 3; i++) begin
         if (t[10 + 4*i +: 4] >= 4'd5)
            t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
      end
      return {t[20:0], 1'b0};
   endfunction

   assign num_sat = (bus.num_value > 10'd999) ? 10'd999 : bus.num_value;
   assign hund    = shift_q[21:18];
   assign tens    = shift_q[17:14];
   assign units   = shift_q[13:10];

   assign bus.wr_ready  = (state_q == IDLE);
   assign bus.num_ready = (state_q == IDLE) && !bus.wr_valid;
   assign bus.busy      = (state_q != IDLE);
   assign bus.char_code = char_code_q;

   // Next state, conversion datapath and the single buffer write port
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      pos_d    = pos_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      mem_we   = 1'b0;
      mem_addr = addr_q;
      mem_data = SPACE_CODE;
      case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            addr_d = addr_q + 8'd1;
            if (addr_q == 8'hFF) state_d = IDLE;
         end
         IDLE: begin
            // Character write wins when both requests arrive together
            if (bus.wr_valid) begin
               mem_we   = 1'b1;
               mem_addr = bus.wr_xy;
               mem_data = bus.wr_code;
            end else if (bus.num_valid) begin
               pos_d   = bus.num_xy;
               shift_d = {12'd0, num_sat};
               cnt_d   = 4'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            shift_d = bcd_step(shift_q);
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd9) state_d = WR0;
         end
         WR0: begin
            mem_we   = 1'b1;
            mem_addr = pos_q;
            mem_data = (hund == 4'd0) ? SPACE_CODE : DIGIT_BASE + {3'b000, hund};
            state_d  = WR1;
         end
         WR1: begin
            // Column wraps inside the row; the row nibble is never touched
            mem_we   = 1'b1;
            mem_addr = {pos_q[7:4], pos_q[3:0] + 4'd1};
            mem_data = (hund == 4'd0 && tens == 4'd0) ? SPACE_CODE : DIGIT_BASE + {3'b000, tens};
            state_d  = WR2;
         end
         WR2: begin
            mem_we   = 1'b1;
            mem_addr = {pos_q[7:4], pos_q[3:0] + 4'd2};
            mem_data = DIGIT_BASE + {3'b000, units};
            state_d  = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end

   // Read port: old contents on a same-cell collision, blank while clearing
   always_comb begin
      char_code_d = (state_q == CLEAR) ? SPACE_CODE : mem[bus.char_xy];
   end

   // Control and read-data registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= CLEAR;
         addr_q      <= 8'd0;
         pos_q       <= 8'd0;
         shift_q     <= 22'd0;
         cnt_q       <= 4'd0;
         char_code_q <= SPACE_CODE;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pos_q       <= pos_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         char_code_q <= char_code_d;
      end
   end

   // Buffer storage; contents survive reset until the next clear sweep
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_data;
   end

endmodule

// File: tb/tb_text_line_server.sv
// tb/tb_text_line_server.sv - directed self-checking bench for text_line_server
module tb_text_line_server;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   text_line_server_if bus ();

   text_line_server dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic read_cell(input logic [7:0] xy, output logic [6:0] code);
      bus.char_xy = xy;
      @(negedge clk);
      code = bus.char_code;
   endtask

   task automatic check_cell(input string tag, input logic [7:0] xy, input logic [6:0] exp);
      logic [6:0] code;
      read_cell(xy, code);
      check(tag, 32'(code), 32'(exp));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!bus.wr_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(bus.wr_ready), 32'd1);
   endtask

   task automatic write_char(input logic [7:0] xy, input logic [6:0] code);
      bus.wr_valid = 1'b1;
      bus.wr_xy    = xy;
      bus.wr_code  = code;
      wait_idle();
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic write_num(input logic [7:0] xy, input logic [9:0] value);
      bus.num_valid = 1'b1;
      bus.num_xy    = xy;
      bus.num_value = value;
      wait_idle();
      @(negedge clk);
      bus.num_valid = 1'b0;
      wait_idle();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_char_code"}, 32'(bus.char_code), 32'h20);
      check({tag, "_wr_ready"},  32'(bus.wr_ready),  32'd0);
      check({tag, "_num_ready"}, 32'(bus.num_ready), 32'd0);
      check({tag, "_busy"},      32'(bus.busy),      32'd1);
   endtask

   // Release reset on a falling edge and count rising edges until wr_ready shows up
   task automatic release_and_clear(input string tag);
      int n;
      int bad;
      logic [6:0] code;
      rst = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.wr_ready && n < 1000);
      check({tag, "_clear_cycles"}, 32'(n), 32'd256);
      bad = 0;
      for (int a = 0; a < 256; a++) begin
         read_cell(8'(a), code);
         if (code !== 7'h20) bad++;
      end
      check({tag, "_clear_cells_bad"}, 32'(bad), 32'd0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b0;
      bus.char_xy   = 8'h00;
      bus.wr_valid  = 1'b0;
      bus.wr_xy     = 8'h00;
      bus.wr_code   = 7'h00;
      bus.num_valid = 1'b0;
      bus.num_xy    = 8'h00;
      bus.num_value = 10'd0;

      repeat (3) @(negedge clk);
      check_reset_values("rst0");
      release_and_clear("boot");

      // Character writes and readback
      write_char(8'h00, 7'h48);
      write_char(8'h01, 7'h50);
      check_cell("rd_00", 8'h00, 7'h48);
      check_cell("rd_01", 8'h01, 7'h50);

      // Number writes with leading-zero suppression and saturation
      write_num(8'h23, 10'd9);
      check_cell("n9_h", 8'h23, 7'h20);
      check_cell("n9_t", 8'h24, 7'h20);
      check_cell("n9_u", 8'h25, 7'h39);
      write_num(8'h23, 10'd105);
      check_cell("n105_h", 8'h23, 7'h31);
      check_cell("n105_t", 8'h24, 7'h30);
      check_cell("n105_u", 8'h25, 7'h35);
      write_num(8'h23, 10'd1000);
      check_cell("n1000_h", 8'h23, 7'h39);
      check_cell("n1000_t", 8'h24, 7'h39);
      check_cell("n1000_u", 8'h25, 7'h39);

      // Column wrap stays in row 1
      write_num(8'h1F, 10'd42);
      check_cell("wrap_h", 8'h1F, 7'h20);
      check_cell("wrap_t", 8'h10, 7'h34);
      check_cell("wrap_u", 8'h11, 7'h32);
      check_cell("wrap_row2_20", 8'h20, 7'h20);
      check_cell("wrap_row2_21", 8'h21, 7'h20);
      check_cell("wrap_row2_23", 8'h23, 7'h39);
      check_cell("wrap_row1_1e", 8'h1E, 7'h20);

      // Simultaneous requests: character first, number next cycle
      bus.wr_valid  = 1'b1;
      bus.wr_xy     = 8'h50;
      bus.wr_code   = 7'h41;
      bus.num_valid = 1'b1;
      bus.num_xy    = 8'h60;
      bus.num_value = 10'd7;
      #1;
      check("both_wr_ready", 32'(bus.wr_ready), 32'd1);
      check("both_num_ready", 32'(bus.num_ready), 32'd0);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      check("after_wr_num_ready", 32'(bus.num_ready), 32'd1);
      @(negedge clk);
      bus.num_valid = 1'b0;
      for (int i = 0; i < 13; i++) begin
         check($sformatf("busy_num_ready_%0d", i), 32'(bus.num_ready), 32'd0);
         check($sformatf("busy_wr_ready_%0d", i), 32'(bus.wr_ready), 32'd0);
         @(negedge clk);
      end
      check("num_ready_14th", 32'(bus.num_ready), 32'd1);
      check_cell("both_chr", 8'h50, 7'h41);
      check_cell("both_h", 8'h60, 7'h20);
      check_cell("both_t", 8'h61, 7'h20);
      check_cell("both_u", 8'h62, 7'h37);

      // Reset in WR1 while the read port shows a non-blank cell
      bus.char_xy   = 8'h00;
      bus.num_valid = 1'b1;
      bus.num_xy    = 8'h70;
      bus.num_value = 10'd123;
      wait_idle();
      @(negedge clk);
      bus.num_valid = 1'b0;
      repeat (11) @(negedge clk);
      check("pre_rst_char_code", 32'(bus.char_code), 32'h48);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      #1;
      check_reset_values("rst_wr1");
      repeat (2) @(negedge clk);
      release_and_clear("rerun");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
